// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 5x5 streaming convolution engine.
// Image geometry, kernel size, data widths, accumulator width and the
// saturation limits of the signed output.
package conv_pkg;

  localparam int IMG_W = 32;            // image width (power of two)
  localparam int IMG_H = 32;            // image height
  localparam int K     = 5;             // kernel size
  localparam int DW    = 8;             // pixel / weight width, signed
  localparam int OW    = 16;            // output width, signed
  localparam int NTAP  = K * K;         // weight count
  localparam int AW    = $clog2(NTAP);  // weight address width
  localparam int PW    = 2 * DW;        // full product width
  localparam int ACC_W = 21;            // accumulator width, signed

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OW - 1)));

  // Clamp the accumulator into the signed output range.
  function automatic logic signed [OW-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) begin
      return OW'(SAT_MAX);
    end else if (a < SAT_MIN) begin
      return OW'(SAT_MIN);
    end
    return OW'(a);
  endfunction

endpackage

// File: rtl/conv_if.sv
// Pixel stream, weight write port and result stream of convolution_top.
//   iValid/iX         : pixel input, raster order
//   iWren/iADDR/iW    : weight register write
//   oY/oValid         : convolution result
// master drives pixels and weights; slave is the convolution engine.
interface conv_if;
  import conv_pkg::*;

  logic                 iValid;
  logic signed [DW-1:0] iX;
  logic                 iWren;
  logic [AW-1:0]        iADDR;
  logic signed [DW-1:0] iW;
  logic signed [OW-1:0] oY;
  logic                 oValid;

  modport master (output iValid, iX, iWren, iADDR, iW, input oY, oValid);
  modport slave  (input iValid, iX, iWren, iADDR, iW, output oY, oValid);

endinterface

// File: rtl/conv_window_5x5.sv
// Sliding 5x5 window generator: pixel counter, K-1 line buffers and the
// window register. Everything advances only on accepted pixels.
//   iCLK, iRST   : clock, synchronous active-high reset
//   i_valid, i_x : accepted pixel
//   o_win        : window, index kr*K+kc, 0 = top-left (oldest)
//   o_win_valid  : window registered this edge completes a valid position
module conv_window_5x5
  import conv_pkg::*;
(
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          i_valid,
  input  logic [DW-1:0] i_x,
  output logic [DW-1:0] o_win [NTAP],
  output logic          o_win_valid
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_win_valid;
  logic [DW-1:0] r_lb  [K-1][IMG_W];  // r_lb[0] = previous row
  logic [DW-1:0] r_win [NTAP];
  logic [DW-1:0] w_col [K];           // new window column, w_col[0] = oldest row

  always_comb begin
    w_col[K-1] = i_x;
    for (int unsigned i = 0; i < K - 1; i++) begin
      w_col[i] = r_lb[K-2-i][r_col];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= i_valid && (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
      if (i_valid) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Line buffers and window hold no reset: stale rows are never part of a
  // valid window.
  always_ff @(posedge iCLK) begin
    if (i_valid) begin
      r_lb[0][r_col] <= i_x;
      for (int unsigned i = 1; i < K - 1; i++) begin
        r_lb[i][r_col] <= r_lb[i-1][r_col];
      end
      for (int unsigned i = 0; i < NTAP; i++) begin
        if ((i % K) == K - 1) begin
          r_win[i] <= w_col[i / K];
        end else begin
          r_win[i] <= r_win[i+1];
        end
      end
    end
  end

  assign o_win       = r_win;
  assign o_win_valid = r_win_valid;

endmodule

// File: rtl/convolution_top.sv
// Streaming 5x5 signed convolution over 32x32 images, one pixel per clock.
// Weight file, 25 multipliers, adder stage and saturating output register.
// Latency from the completing pixel's edge k: result valid after edge k+3.
//   iCLK, iRST : clock, synchronous active-high reset
//   bus        : conv_if slave (pixel in, weight write, result out)
module convolution_top
  import conv_pkg::*;
(
  input logic   iCLK,
  input logic   iRST,
  conv_if.slave bus
);

  localparam logic [AW-1:0] ADDR_LIM = AW'(NTAP);

  logic [DW-1:0]           w_win [NTAP];
  logic                    w_win_valid;
  logic signed [DW-1:0]    r_w    [NTAP];
  logic signed [PW-1:0]    r_prod [NTAP];
  logic                    r_prod_valid;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_sum;
  logic                    r_sum_valid;
  logic signed [OW-1:0]    r_y;
  logic                    r_y_valid;

  conv_window_5x5 u_window (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .i_valid     (bus.iValid),
    .i_x         (bus.iX),
    .o_win       (w_win),
    .o_win_valid (w_win_valid)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_w <= '{default: '0};
    end else if (bus.iWren && (bus.iADDR < ADDR_LIM)) begin
      r_w[bus.iADDR] <= bus.iW;
    end
  end

  // Products sample the weight file before this edge's write lands, so
  // reloads for the next image never reach windows already formed.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_prod_valid <= 1'b0;
    end else begin
      r_prod_valid <= w_win_valid;
    end
    for (int unsigned i = 0; i < NTAP; i++) begin
      r_prod[i] <= PW'($signed(w_win[i])) * PW'(r_w[i]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      w_sum = w_sum + ACC_W'(r_prod[i]);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= r_prod_valid;
    end
    r_sum <= w_sum;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= r_sum_valid;
      if (r_sum_valid) begin
        r_y <= saturate(r_sum);
      end
    end
  end

  assign bus.oY     = r_y;
  assign bus.oValid = r_y_valid;

endmodule

// File: tb/tb_convolution_top.sv
// Directed bench for convolution_top with a reference image/weight model
// feeding an expected-result queue; the monitor pops one entry per oValid.
module tb_convolution_top;
  import conv_pkg::*;

  typedef struct {
    int    val;
    int    cyc;
    string tag;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  conv_if bus ();

  convolution_top dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    out_cnt = 0;
  int    last_y = 0;
  exp_t  q[$];
  exp_t  e;
  string cur_tag = "reset";

  int mw  [NTAP];
  int img [IMG_H][IMG_W];
  int mrow = 0;
  int mcol = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Output monitor: scoreboard pop, latency and hold checks.
  initial forever begin
    @(negedge iCLK);
    if (bus.oValid === 1'b1) begin
      out_cnt++;
      checks++;
      assert (q.size() > 0)
        else begin errors++; $error("FAIL %s unexpected_output obs=%0d exp=none", cur_tag, bus.oY); end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (int'(bus.oY) === e.val)
          else begin errors++; $error("FAIL %s value obs=%0d exp=%0d", e.tag, bus.oY, e.val); end
        checks++;
        assert (cyc === e.cyc)
          else begin errors++; $error("FAIL %s latency obs_cyc=%0d exp_cyc=%0d", e.tag, cyc, e.cyc); end
      end
      last_y = int'(bus.oY);
    end else begin
      checks++;
      assert (bus.oValid === 1'b0 && int'(bus.oY) === last_y)
        else begin errors++; $error("FAIL %s idle_hold obs=%0d/%b exp=%0d/0", cur_tag, bus.oY, bus.oValid, last_y); end
    end
  end

  task automatic step(input bit v, input int x, input bit we, input int addr, input int wd);
    int s;
    bus.iValid = v;
    bus.iX     = DW'(x);
    bus.iWren  = we;
    bus.iADDR  = AW'(addr);
    bus.iW     = DW'(wd);
    @(posedge iCLK);
    #1;
    bus.iValid = 1'b0;
    bus.iWren  = 1'b0;
    if (we && addr < NTAP) mw[addr] = wd;
    if (v) begin
      img[mrow][mcol] = x;
      if (mrow >= K - 1 && mcol >= K - 1) begin
        s = 0;
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++)
            s += mw[kr*K+kc] * img[mrow-K+1+kr][mcol-K+1+kc];
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        q.push_back('{val: s, cyc: cyc + 3, tag: cur_tag});
      end
      if (mcol == IMG_W - 1) begin
        mcol = 0;
        mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    bus.iValid = 1'b0;
    bus.iWren  = 1'b0;
    @(posedge iCLK);
    #1;
    q.delete();
    last_y = 0;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    mrow = 0;
    mcol = 0;
    for (int i = 0; i < NTAP; i++) mw[i] = 0;
  endtask

  task automatic load_all(input int v);
    for (int a = 0; a < NTAP; a++) step(1'b0, 0, 1'b1, a, v);
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 0, 1'b0, 0, 0);
    checks++;
    assert (q.size() == 0)
      else begin errors++; $error("FAIL %s missing_outputs obs=%0d exp=0", cur_tag, q.size()); end
  endtask

  task automatic check_count(input int expc);
    checks++;
    assert (out_cnt == expc)
      else begin errors++; $error("FAIL %s output_count obs=%0d exp=%0d", cur_tag, out_cnt, expc); end
  endtask

  initial begin
    bus.iValid = 1'b0;
    bus.iX     = '0;
    bus.iWren  = 1'b0;
    bus.iADDR  = '0;
    bus.iW     = '0;
    do_reset();
    checks++;
    assert (bus.oValid === 1'b0 && bus.oY === '0)
      else begin errors++; $error("FAIL reset_state obs=%0d/%b exp=0/0", bus.oY, bus.oValid); end

    // All ones, six back-to-back images; out-of-range writes must be ignored.
    cur_tag = "all_ones";
    load_all(1);
    step(1'b0, 0, 1'b1, 25, 55);
    step(1'b0, 0, 1'b1, 31, -9);
    out_cnt = 0;
    for (int p = 0; p < 6 * IMG_W * IMG_H; p++) step(1'b1, 1, 1'b0, 0, 0);
    drain();
    check_count(4704);

    // Single top-left tap, x = column index.
    cur_tag = "single_tap";
    do_reset();
    step(1'b0, 0, 1'b1, 0, 1);
    out_cnt = 0;
    for (int p = 0; p < IMG_W * IMG_H; p++) step(1'b1, p % IMG_W, 1'b0, 0, 0);
    drain();
    check_count(784);

    // Saturation corners.
    cur_tag = "sat_pos";
    do_reset();
    load_all(127);
    for (int p = 0; p < 200; p++) step(1'b1, 127, 1'b0, 0, 0);
    drain();
    cur_tag = "sat_neg";
    do_reset();
    load_all(127);
    for (int p = 0; p < 200; p++) step(1'b1, -128, 1'b0, 0, 0);
    drain();
    cur_tag = "sat_negneg";
    do_reset();
    load_all(-128);
    for (int p = 0; p < 200; p++) step(1'b1, -128, 1'b0, 0, 0);
    drain();

    // Random bubbles on the single-tap stream.
    cur_tag = "bubbles";
    do_reset();
    step(1'b0, 0, 1'b1, 0, 1);
    out_cnt = 0;
    for (int p = 0; p < IMG_W * IMG_H; p++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, 0, 1'b0, 0, 0);
      step(1'b1, p % IMG_W, 1'b0, 0, 0);
    end
    drain();
    check_count(784);

    // Filter reload during the first 25 pixels of the next image.
    cur_tag = "reload";
    do_reset();
    load_all(1);
    out_cnt = 0;
    for (int p = 0; p < IMG_W * IMG_H; p++) step(1'b1, 1, 1'b0, 0, 0);
    for (int p = 0; p < IMG_W * IMG_H; p++) begin
      if (p < NTAP) step(1'b1, 1, 1'b1, p, 2);
      else step(1'b1, 1, 1'b0, 0, 0);
    end
    drain();
    check_count(1568);

    // Reset at pixel 500, then restart with weights cleared.
    cur_tag = "mid_reset";
    for (int p = 0; p < 500; p++) step(1'b1, 1, 1'b0, 0, 0);
    do_reset();
    for (int p = 0; p < 300; p++) step(1'b1, int'($urandom_range(1, 100)), 1'b0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/convolution_top.md
# convolution_top

Streaming 5×5 2-D convolution engine for 32×32 signed 8-bit images, one pixel per clock in raster order. It holds a 25-entry weight register file, loaded through a side-band write port, and emits one signed 16-bit result per valid 28×28 output position. It sits in the feature-extraction datapath as the per-filter convolution stage. Back-to-back images and filter reloads are supported without gaps.

## Interface
Parameters:
- IMG_W, 32: image width (power of two)
- IMG_H, 32: image height
- K, 5: kernel size
- DW, 8: pixel and weight width, signed
- OW, 16: output width, signed

Ports:
- iCLK  in  1  clock; all state changes on the rising edge
- iRST  in  1  reset; synchronous, active-high
- iValid  in  1  iX carries a pixel this cycle
- iX  in  DW  signed pixel, raster order (row-major, col 0 first)
- iWren  in  1  weight write enable
- iADDR  in  5  weight address, 0..24
- iW  in  DW  signed weight data
- oY  out  OW  signed convolution result
- oValid  out  1  oY valid this cycle

## Operation
- **Weight file:** 25 × DW signed registers.
  - On iWren, W[iADDR] <= iW. This is independent of iValid.
  - iADDR ≥ 25 is ignored.
  - Addressing is row-major: addr = kr*5 + kc. W[0] multiplies the window's top-left (oldest) pixel; W[24] multiplies the newest pixel.
- **Pixel counter:** counts accepted pixels (iValid=1) from 0 to 1023, then wraps to 0. col = cnt[4:0], row = cnt[9:5]. The next image follows immediately with no gap.
- **Window generation:**
  - 4 line buffers of IMG_W × DW, plus a 5×5 window register.
  - These shift only on accepted pixels.
  - iValid=0 freezes the counter, line buffers and window.
- **Output condition:** the window is valid when the accepted pixel has row ≥ 4 and col ≥ 4. This gives 784 results per image.
- **Result:** oY for window (r, c) is sum over kr, kc of W[kr*5+kc] × X[r-4+kr][c-4+kc].
  - Products are full 16-bit signed.
  - The accumulator is at least 21 bits signed.
  - The final value saturates to the OW range [-32768, 32767]. There is no wrap.
- **Weight timing:** products use the weight values present before the clock edge that captures them. Weights written for the next image (first 25 pixels) therefore never corrupt results still in the pipeline from the previous image.
- **Pipeline:** the arithmetic pipeline runs every cycle and carries a valid bit. It does not stall.

## Timing
- **Latency:** the pixel completing a valid window is accepted at edge k; oY and oValid are asserted for exactly one cycle after edge k+3. The stages are:
  - window update
  - product register
  - adder-tree register
  - saturate/output register
- **Continuous stream from edge 0:**
  - first oValid after edge 135 (pixel 132);
  - last result of the image after edge 1026.
- **Idle:** oValid is 0 whenever no valid window is in flight. oY holds its last value when oValid=0.
- **Reset:**
  - oY=0, oValid=0, pixel counter=0, pipeline valid bits=0, all weights=0.
  - Line buffer contents are don't-care; they are never used before being refilled.
  - Reset mid-image discards any in-flight results. The next accepted pixel is treated as pixel (0,0).
- **Simultaneous events:** iWren and iValid in the same cycle are both honored.

## Structure
- **Shared package conv_pkg:** IMG_W, IMG_H, K, DW, OW, accumulator width (21), and the saturation limits.
- **Sub-module conv_window_5x5:**
  - contains the line buffers, window register and pixel counter;
  - outputs 25 window pixels plus a window-valid flag.
- **Top level:** the weight file, the 25 multipliers, the adder tree and the saturation stage.

## Test plan
1. **All ones:** x=1 for all 1024 pixels and W=1 for all 25. Expect 784 outputs of 25, first oValid after edge 135. Repeat for 6 back-to-back images: 4704 outputs, all equal to 25.
2. **Single tap:** W[0]=1, others 0, x = column index. Expect each output row to be 0, 1, ..., 27, matching the top-left window pixel.
3. **Saturation:**
   - all x=127, W=127 → 32767;
   - x=-128, W=127 → -32768;
   - x=-128, W=-128 → 32767.
4. **Bubbles:** insert random iValid=0 cycles. Expect the same output value sequence as scenario 2, each output appearing 3 cycles after its completing pixel.
5. **Filter reload:** image 1 with W=1, then image 2 with W=2 written during its first 25 pixels. Expect image 1 tail outputs of 25, then image 2 outputs of 50.
6. **Mid-image reset:** assert iRST at pixel 500, then restart the stream. Expect no oValid until 133 new pixels have been accepted, and weights equal to 0 until reloaded.
